meter_time_bank: RTL and testbench
==================================

# meter_time_bank

Holds the parking meter's remaining time, 0–9999 seconds, as a binary register. It adds time on single-cycle coin pulses, presets on load pulses, and decrements on the 1 Hz tick. It also converts the held value to four BCD digits with an iterative double-dabble engine. It sits between the debounced button pulses and the display/blink FSM, which consumes `bcd`, `low` and `expired`.

## Interface
- `MAX_TIME`, default 9999: upper bound on the held time, in seconds.
- `LOW_THRESH`, default 200: `low` asserts while `count < LOW_THRESH`.

- `clk` in 1: system clock. All state updates on its rising edge.
- `reset` in 1: synchronous, active-high. It clears all state.
- `sec_tick` in 1: one-`clk` pulse, once per second.
- `add10`, `add180`, `add200`, `add550` in 1 each: single-cycle pulses from the debouncers.
- `load10`, `load205` in 1 each: single-cycle pulses that preset the count to 10 or 205.
- `count` out 14: current remaining time, binary.
- `bcd` out 16: last completed conversion, arranged as [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- `bcd_valid` out 1: one-cycle pulse when `bcd` is updated.
- `busy` out 1: high while a conversion is in progress.
- `low` out 1: registered, equals `count < LOW_THRESH`.
- `expired` out 1: registered, equals `count == 0`.

## Operation
- **Reset values.** `count`=0, `bcd`=0, `bcd_valid`=0, `busy`=0, `low`=1, `expired`=1. The converter state is IDLE and the snapshot is 0.
- **Count update priority, per cycle:** `reset` > `load205` > `load10` > arithmetic.
- **Arithmetic.**
  - `dec` = 1 if `sec_tick` and `count` != 0, else 0.
  - `sum` = 10·`add10` + 180·`add180` + 200·`add200` + 550·`add550`. All simultaneous add pulses are summed.
  - `next` = `count` − `dec` + `sum`, computed 15 bits wide, then capped per Configuration.
- **Decrement at 0.** `count` stays 0; there is no underflow.
- **Loads.** A load overrides any add or tick in the same cycle.
- **Converter FSM.**
  - **IDLE:** If `count` != snapshot, latch snapshot ← `count`, clear the shift register, set `busy`, and go to SHIFT.
  - **SHIFT:** Runs 14 cycles. Each cycle adds 3 to every BCD nibble ≥ 5, then shifts left one bit, MSB first from the snapshot. After the 14th shift, go to DONE.
  - **DONE:** Write `bcd`, pulse `bcd_valid`, clear `busy`, and go to IDLE.
- **Count changes mid-conversion.** The conversion finishes with the old snapshot. IDLE then detects the mismatch and reconverts. `bcd` is never partially updated.
- **Reset mid-conversion.** The FSM returns to IDLE, `bcd`=0, and no `bcd_valid` is issued.

## Timing
- `count`, `low` and `expired` update on the edge after the input pulse, so latency is 1 cycle.
- `low` and `expired` are derived from the next-state value, so they track `count` on the same edge.
- Conversion timeline, where E is the edge on which `count` changes:
  - E+1: IDLE latches the snapshot.
  - E+2 through E+15: 14 SHIFT cycles.
  - E+16: DONE writes `bcd` and pulses `bcd_valid`.
  - Worst-case staleness is 31 cycles, far below one `sec_tick` period.
- Pulse inputs must be one `clk` wide. A held input adds once per cycle, and this block does not guard against it.

## Configuration
- **With `METER_SATURATE_EN` defined:** a `next` above `MAX_TIME` is clamped to `MAX_TIME`. Example: 9990 + 550 → 9999.
- **Without it:** an arithmetic result above `MAX_TIME` is discarded and `count` keeps its old value, including any decrement in that cycle. Example: 9990 + 550 → 9990.
- Loads and reset are identical in both builds.

## Test plan
- **Reset and load.** `reset` for 2 cycles → `count`=0, `expired`=1, `low`=1, `bcd`=0x0000. Then `load205` → `count`=205, `low`=0, and 16 cycles later `bcd`=0x0205 with one `bcd_valid`.
- **Add and countdown.** From 0, `add180` then `add10` → 190. Four `sec_tick` → 186, `bcd`=0x0186. `expired`=0 and `low`=1 throughout.
- **Simultaneous events.** At 100, `add550`, `add200` and `sec_tick` in the same cycle → 849. At 0, `sec_tick` and `add10` together → 10.
- **Cap.**
  - With `METER_SATURATE_EN`: load 9990 via repeated adds, then `add550` → 9999, `bcd`=0x9999.
  - Without it: the same stimulus leaves `count` at 9990.
- **Mid-conversion change.** `add10` 5 cycles after a prior change. Required: the first `bcd_valid` carries the old value, a second `bcd_valid` follows 16 cycles later with the new value, and there are no torn digits.
- **Priority and reset mid-op.** `load10`, `load205` and `add550` together → 205. Assert `reset` 7 cycles into a conversion → `busy`=0 on the next edge, no `bcd_valid`, `bcd`=0.

Source files
------------

// File: rtl/meter_time_bank.sv
// Parking-meter time bank: binary remaining-time register plus an iterative
// double-dabble BCD converter. Optional build macro: METER_SATURATE_EN.
module meter_time_bank #(
  parameter int unsigned MAX_TIME   = 9999,
  parameter int unsigned LOW_THRESH = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sec_tick,
  input  logic        add10,
  input  logic        add180,
  input  logic        add200,
  input  logic        add550,
  input  logic        load10,
  input  logic        load205,
  output logic [13:0] count,
  output logic [15:0] bcd,
  output logic        bcd_valid,
  output logic        busy,
  output logic        low,
  output logic        expired,
  output logic [1:0]  dbg_state
);

  // Pulse handshake: every input is a one-cycle strobe with no ready; the
  // block accepts it on the rising edge it is high, and bcd_valid is a
  // one-cycle strobe that the consumer must take on that cycle.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } conv_state_e;

  localparam logic [14:0] MAX_W = 15'(MAX_TIME);
  localparam logic [13:0] MAX_C = 14'(MAX_TIME);
  localparam logic [14:0] LOW_W = 15'(LOW_THRESH);

  logic [13:0] count_q, count_d;
  logic        low_q, low_d;
  logic        expired_q, expired_d;
  logic        dec;
  logic [14:0] sum, nxt;

  conv_state_e state_q, state_d;
  logic [13:0] snap_q, snap_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] work_q, work_d;
  logic [15:0] adj;
  logic [3:0]  step_q, step_d;
  logic [15:0] bcd_q, bcd_d;
  logic        bcd_valid_q, bcd_valid_d;
  logic        busy_q, busy_d;

  always_comb begin
    dec = sec_tick && (count_q != 14'd0);
    sum = (add10  ? 15'd10  : 15'd0) + (add180 ? 15'd180 : 15'd0) +
          (add200 ? 15'd200 : 15'd0) + (add550 ? 15'd550 : 15'd0);
    nxt = {1'b0, count_q} - {14'd0, dec} + sum;
    count_d = count_q;
    if (load205) begin
      count_d = 14'd205;
    end else if (load10) begin
      count_d = 14'd10;
    end else if (nxt > MAX_W) begin
`ifdef METER_SATURATE_EN
      count_d = MAX_C;
`else
      count_d = count_q;
`endif
    end else begin
      count_d = nxt[13:0];
    end
    // Flags come from the next value so they move on the same edge as count.
    low_d     = ({1'b0, count_d} < LOW_W);
    expired_d = (count_d == 14'd0);
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      adj[4*i +: 4] = (work_q[4*i +: 4] >= 4'd5) ? work_q[4*i +: 4] + 4'd3
                                                  : work_q[4*i +: 4];
    end
  end

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    bin_d       = bin_q;
    work_d      = work_q;
    step_d      = step_q;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != snap_q) begin
          snap_d  = count_q;
          bin_d   = count_q;
          work_d  = 16'd0;
          step_d  = 4'd0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        work_d = {adj[14:0], bin_q[13]};
        bin_d  = {bin_q[12:0], 1'b0};
        step_d = step_q + 4'd1;
        if (step_q == 4'd13) state_d = S_DONE;
      end
      S_DONE: begin
        // bcd only ever takes a fully converted word.
        bcd_d       = work_q;
        bcd_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= 14'd0;
      low_q       <= 1'b1;
      expired_q   <= 1'b1;
      state_q     <= S_IDLE;
      snap_q      <= 14'd0;
      bin_q       <= 14'd0;
      work_q      <= 16'd0;
      step_q      <= 4'd0;
      bcd_q       <= 16'd0;
      bcd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      count_q     <= count_d;
      low_q       <= low_d;
      expired_q   <= expired_d;
      state_q     <= state_d;
      snap_q      <= snap_d;
      bin_q       <= bin_d;
      work_q      <= work_d;
      step_q      <= step_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign count     = count_q;
  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign busy      = busy_q;
  assign low       = low_q;
  assign expired   = expired_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_meter_time_bank.sv
// Randomised and directed bench for meter_time_bank against a cycle-level
// behavioural model (integer arithmetic, divide-based BCD, conversion timer).
module tb_meter_time_bank;

  localparam int unsigned MAX_TIME   = 9999;
  localparam int unsigned LOW_THRESH = 200;

  localparam logic [7:0] SEC  = 8'h01;
  localparam logic [7:0] A10  = 8'h02;
  localparam logic [7:0] A180 = 8'h04;
  localparam logic [7:0] A200 = 8'h08;
  localparam logic [7:0] A550 = 8'h10;
  localparam logic [7:0] L10  = 8'h20;
  localparam logic [7:0] L205 = 8'h40;
  localparam logic [7:0] RST  = 8'h80;

  logic        clk;
  logic        reset, sec_tick, add10, add180, add200, add550, load10, load205;
  logic [13:0] count;
  logic [15:0] bcd;
  logic        bcd_valid, busy, low, expired;
  logic [1:0]  dbg_state;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned v_cnt   = 0;
  logic [15:0] got_q[$];

  meter_time_bank #(.MAX_TIME(MAX_TIME), .LOW_THRESH(LOW_THRESH)) dut (
    .clk(clk), .reset(reset), .sec_tick(sec_tick),
    .add10(add10), .add180(add180), .add200(add200), .add550(add550),
    .load10(load10), .load205(load205),
    .count(count), .bcd(bcd), .bcd_valid(bcd_valid), .busy(busy),
    .low(low), .expired(expired), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  function automatic int unsigned next_count(input int unsigned c, input logic [7:0] v);
    int unsigned n;
    if (v[6]) return 205;
    if (v[5]) return 10;
    n = c + (v[1] ? 10 : 0) + (v[2] ? 180 : 0) + (v[3] ? 200 : 0) + (v[4] ? 550 : 0);
    if (v[0] && c != 0) n = n - 1;
    if (n > MAX_TIME) begin
`ifdef METER_SATURATE_EN
      return MAX_TIME;
`else
      return c;
`endif
    end
    return n;
  endfunction

  function automatic logic [15:0] to_bcd(input int unsigned v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  int unsigned m_count = 0, m_snap = 0, m_left = 0;
  logic [15:0] m_bcd = 16'd0;
  logic        m_valid = 1'b0, m_busy = 1'b0, m_low = 1'b1, m_exp = 1'b1, m_ready = 1'b0;
  logic [7:0]  in_vec;

  assign in_vec = {reset, load205, load10, add550, add200, add180, add10, sec_tick};

  always @(posedge clk) begin
    if (reset) begin
      m_count <= 0; m_snap <= 0; m_left <= 0; m_bcd <= 16'd0;
      m_valid <= 1'b0; m_busy <= 1'b0; m_low <= 1'b1; m_exp <= 1'b1;
      m_ready <= 1'b1;
    end else begin
      m_valid <= 1'b0;
      // A conversion takes 15 edges after the snapshot edge (14 shifts + write).
      if (m_left == 0) begin
        if (m_count != m_snap) begin
          m_snap <= m_count; m_left <= 15; m_busy <= 1'b1;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_bcd <= to_bcd(m_snap); m_valid <= 1'b1; m_busy <= 1'b0;
        end
      end
      m_count <= next_count(m_count, in_vec);
      m_low   <= (next_count(m_count, in_vec) < LOW_THRESH);
      m_exp   <= (next_count(m_count, in_vec) == 0);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_ready) begin
      chk("count",     count,     m_count);
      chk("bcd",       bcd,       m_bcd);
      chk("bcd_valid", bcd_valid, m_valid);
      chk("busy",      busy,      m_busy);
      chk("low",       low,       m_low);
      chk("expired",   expired,   m_exp);
      if (bcd_valid) begin
        v_cnt++;
        got_q.push_back(bcd);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic [7:0] v);
    {reset, load205, load10, add550, add200, add180, add10, sec_tick} = v;
    @(posedge clk);
    @(negedge clk);
    {reset, load205, load10, add550, add200, add180, add10, sec_tick} = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(8'h00);
  endtask

  initial begin
    int unsigned v0;
    logic [7:0] rv;
    {reset, load205, load10, add550, add200, add180, add10, sec_tick} = 8'h00;
    @(negedge clk);

    // Reset and load
    cyc(RST); cyc(RST);
    chk("rst_count", count, 0);
    chk("rst_expired", expired, 1);
    chk("rst_low", low, 1);
    chk("rst_bcd", bcd, 16'h0000);
    v0 = v_cnt;
    cyc(L205);
    chk("load205_count", count, 205);
    chk("load205_low", low, 0);
    idle(17);
    chk("load205_bcd", bcd, 16'h0205);
    chk("load205_valid_pulses", v_cnt - v0, 1);

    // Add and countdown
    cyc(RST);
    cyc(A180); cyc(A10);
    chk("add_190", count, 190);
    repeat (4) begin cyc(SEC); idle(3); end
    chk("tick_186", count, 186);
    idle(35);
    chk("tick_bcd", bcd, 16'h0186);
    chk("tick_low", low, 1);
    chk("tick_expired", expired, 0);

    // Simultaneous events
    cyc(RST);
    repeat (10) cyc(A10);
    chk("sim_100", count, 100);
    cyc(A550 | A200 | SEC);
    chk("sim_849", count, 849);
    cyc(RST);
    cyc(SEC | A10);
    chk("sim_zero_tick_add", count, 10);

    // Cap
    cyc(RST);
    repeat (18) cyc(A550);
    repeat (9) cyc(A10);
    chk("cap_9990", count, 9990);
    cyc(A550);
    idle(35);
`ifdef METER_SATURATE_EN
    chk("cap_count", count, 9999);
    chk("cap_bcd", bcd, 16'h9999);
`else
    chk("cap_count", count, 9990);
    chk("cap_bcd", bcd, 16'h9990);
`endif

    // Mid-conversion change
    cyc(RST);
    got_q.delete();
    cyc(A10);
    idle(4);
    cyc(A10);
    idle(40);
    chk("mid_valid_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("mid_first_bcd", got_q[0], 16'h0010);
      chk("mid_second_bcd", got_q[1], 16'h0020);
    end

    // Priority and reset mid-conversion
    cyc(RST);
    cyc(L10 | L205 | A550);
    chk("prio_205", count, 205);
    idle(7);
    chk("prio_busy_before", busy, 1);
    cyc(RST);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_bcd", bcd, 16'h0000);
    v0 = v_cnt;
    idle(30);
    chk("rstmid_no_valid", v_cnt - v0, 0);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      rv = 8'h00;
      rv[0] = ($urandom_range(0, 3) == 0);
      rv[1] = ($urandom_range(0, 11) == 0);
      rv[2] = ($urandom_range(0, 11) == 0);
      rv[3] = ($urandom_range(0, 11) == 0);
      rv[4] = ($urandom_range(0, 11) == 0);
      rv[5] = ($urandom_range(0, 59) == 0);
      rv[6] = ($urandom_range(0, 59) == 0);
      rv[7] = ($urandom_range(0, 299) == 0);
      cyc(rv);
    end
    idle(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
